// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU byte sequencer: ALU opcodes and result framing widths.
package alu_uart_sequencer_pkg;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RES_W  = 2 * BYTE_W;

endpackage

// File: rtl/byte_timeout_counter.sv
// Counts idle cycles between bytes of a frame; expired stays high once the limit is reached.
module byte_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // A zero limit disables the timeout entirely.
    always_comb begin
        expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && !expired && (TIMEOUT_CYCLES != 0)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, OP bytes from the UART receiver, loads them into the ALU and
// returns the zero-extended result as a low byte followed by a high byte.
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int unsigned DATA_BUS       = 8,
    parameter int unsigned OP_BUS         = 6,
    parameter int unsigned ALU_WAIT       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                tx_busy,
    input  logic                tx_done,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic [DATA_BUS-1:0] op_a_bus,
    output logic [DATA_BUS-1:0] op_b_bus,
    output logic [OP_BUS-1:0]   op_code_bus,
    output logic [2:0]          enables,
    input  logic [DATA_BUS:0]   result_bus,
    output logic                busy
);

    typedef enum logic [3:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        LOAD,
        WAIT_ALU,
        SEND_LO,
        TX_LO,
        SEND_HI,
        TX_HI
    } state_t;

    localparam int unsigned WAIT_W = $clog2(ALU_WAIT);

    state_t              state, state_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
    logic                wait_done;
    logic [RES_W-1:0]    res, res_d;
    logic                tx_start_d;
    logic [7:0]          tx_data_d;
    logic [DATA_BUS-1:0] op_a_d, op_b_d;
    logic [OP_BUS-1:0]   op_code_d;
    logic [2:0]          enables_d;
    logic                busy_d;
    logic                in_frame;
    logic                timed_out;

    // The ALU samples the operands on the edge closing LOAD; result is taken ALU_WAIT edges later.
    assign wait_done = (wait_cnt == WAIT_W'(ALU_WAIT - 1));
    assign in_frame  = (state == WAIT_B) || (state == WAIT_OP);

    byte_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (rx_done || !in_frame),
        .run     (in_frame),
        .expired (timed_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= WAIT_A;
            wait_cnt    <= '0;
            res         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            op_a_bus    <= '0;
            op_b_bus    <= '0;
            op_code_bus <= '0;
            enables     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            res         <= res_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            op_a_bus    <= op_a_d;
            op_b_bus    <= op_b_d;
            op_code_bus <= op_code_d;
            enables     <= enables_d;
            busy        <= busy_d;
        end
    end

    // A byte arriving in the same cycle as the timeout wins over the timeout.
    always_comb begin
        state_d = state;
        case (state)
            WAIT_A:   if (rx_done) state_d = WAIT_B;
            WAIT_B:   if (rx_done) state_d = WAIT_OP; else if (timed_out) state_d = WAIT_A;
            WAIT_OP:  if (rx_done) state_d = LOAD;    else if (timed_out) state_d = WAIT_A;
            LOAD:     state_d = WAIT_ALU;
            WAIT_ALU: if (wait_done) state_d = SEND_LO;
            SEND_LO:  if (!tx_busy) state_d = TX_LO;
            TX_LO:    if (tx_done) state_d = SEND_HI;
            SEND_HI:  if (!tx_busy) state_d = TX_HI;
            TX_HI:    if (tx_done) state_d = WAIT_A;
            default:  state_d = WAIT_A;
        endcase
    end

    // Next values of the registered outputs, derived from the current and next state.
    always_comb begin
        op_a_d     = op_a_bus;
        op_b_d     = op_b_bus;
        op_code_d  = op_code_bus;
        res_d      = res;
        tx_data_d  = tx_data;
        wait_cnt_d = '0;
        case (state)
            WAIT_A:   if (rx_done) op_a_d = rx_data[DATA_BUS-1:0];
            WAIT_B:   if (rx_done) op_b_d = rx_data[DATA_BUS-1:0];
            WAIT_OP:  if (rx_done) op_code_d = rx_data[OP_BUS-1:0];
            WAIT_ALU: begin
                if (wait_done) begin
                    res_d               = '0;
                    res_d[DATA_BUS:0]   = result_bus;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            SEND_LO:  if (!tx_busy) tx_data_d = res[BYTE_W-1:0];
            SEND_HI:  if (!tx_busy) tx_data_d = res[RES_W-1:BYTE_W];
            default:  ;
        endcase
        tx_start_d = ((state == SEND_LO) || (state == SEND_HI)) && !tx_busy;
        enables_d  = (state_d == LOAD) ? '1 : '0;
        busy_d     = (state_d != WAIT_A);
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Randomised scoreboard bench for alu_uart_sequencer with a stand-in ALU and UART transmitter.
module tb_alu_uart_sequencer;
    import alu_uart_sequencer_pkg::*;

    localparam int unsigned AW = 3;
    localparam int unsigned TO = 100;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
    } frame_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] op_a_bus;
    logic [7:0] op_b_bus;
    logic [5:0] op_code_bus;
    logic [2:0] enables;
    logic [8:0] result_bus;
    logic       busy;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned cyc = 0;
    int unsigned tx_seen = 0;

    frame_t      frame_q [$];
    logic [7:0]  byte_q  [$];
    int unsigned lat_q   [$];

    logic [7:0] alu_a = '0, alu_b = '0;
    logic [5:0] alu_op = '0;
    logic [7:0] launched;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    alu_uart_sequencer #(
        .DATA_BUS       (8),
        .OP_BUS         (6),
        .ALU_WAIT       (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .op_a_bus    (op_a_bus),
        .op_b_bus    (op_b_bus),
        .op_code_bus (op_code_bus),
        .enables     (enables),
        .result_bus  (result_bus),
        .busy        (busy)
    );

    // ALU behaviour as seen on the bytes: 9-bit result, carry only for ADD.
    function automatic int unsigned alu_ref(input int unsigned a, input int unsigned b,
                                            input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return (a + 256 - b) % 256;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return 255 - (a | b);
            OP_SRA:  return (a / 2) + (a >= 128 ? 128 : 0);
            OP_SRL:  return a / 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] pick_op(input int unsigned i);
        case (i)
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_XOR;
            5: return OP_NOR;
            6: return OP_SRA;
            7: return OP_SRL;
            default: return 6'h3F;
        endcase
    endfunction

    // Stand-in ALU: loads on its strobes, result is combinational from the loaded registers.
    always @(posedge clock) begin
        if (enables[0]) alu_a  <= op_a_bus;
        if (enables[1]) alu_b  <= op_b_bus;
        if (enables[2]) alu_op <= op_code_bus;
    end
    assign result_bus = 9'(alu_ref(alu_a, alu_b, alu_op));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap, output int unsigned at);
        step(gap);
        rx_data = b;
        rx_done = 1'b1;
        step(1);
        rx_done = 1'b0;
        at = cyc;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input int unsigned ga, input int unsigned gb, input int unsigned gop,
                              input bit expect_tx);
        frame_t f;
        int unsigned at, r;
        f.a = a; f.b = b; f.op = op[5:0];
        frame_q.push_back(f);
        send_byte(a, ga, at);
        send_byte(b, gb, at);
        send_byte(op, gop, at);
        if (expect_tx) begin
            r = alu_ref(a, b, op[5:0]);
            byte_q.push_back(8'(r % 256));
            byte_q.push_back(8'(r / 256));
            lat_q.push_back(at + 2 + AW);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((busy || tx_busy) && n < 2000) begin step(1); n++; end
        if (busy || tx_busy) begin
            checks++;
            $display("FAIL wait_idle: busy=%0b tx_busy=%0b, expected both 0 within 2000 cycles", busy, tx_busy);
        end
    endtask

    task automatic wait_tx(input int unsigned target);
        int unsigned n = 0;
        while (tx_seen < target && n < 2000) begin step(1); n++; end
        check("wait_tx_count", tx_seen, target);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_op_a"}, op_a_bus, 0);
        check({tag, "_op_b"}, op_b_bus, 0);
        check({tag, "_op_code"}, op_code_bus, 0);
        check({tag, "_enables"}, enables, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Transmitter: busy for 10 cycles after each accepted start, then a tx_done pulse.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clock);
            tx_done = 1'b0;
            if (tx_start && !tx_busy) begin
                launched = tx_data;
                tx_busy  = 1'b1;
                repeat (10) @(negedge clock);
                check("tx_data_hold", tx_data, launched);
                tx_busy = 1'b0;
                tx_done = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes the ALU or the transmitter.
    initial begin
        bit hi_next = 1'b0;
        bit en_prev = 1'b0;
        frame_t f;
        forever begin
            @(posedge clock); #1;
            if (en_prev) check("enables_one_cycle", enables, 0);
            en_prev = (enables != 0);
            if (enables != 0) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_enables: got %b, none expected", enables);
                end else begin
                    f = frame_q.pop_front();
                    check("enables", enables, 3'b111);
                    check("op_a", op_a_bus, f.a);
                    check("op_b", op_b_bus, f.b);
                    check("op_code", op_code_bus, f.op);
                end
            end
            if (tx_start) begin
                tx_seen++;
                check("tx_start_while_busy", tx_busy, 0);
                if (byte_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_tx_start: tx_data=%0h, none expected", tx_data);
                end else begin
                    check(hi_next ? "tx_byte_hi" : "tx_byte_lo", tx_data, byte_q.pop_front());
                    if (!hi_next && lat_q.size() != 0) check("latency", cyc, lat_q.pop_front());
                    hi_next = !hi_next;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned at, base;
        logic [7:0] opb;
        reset   = 1'b1;
        rx_data = '0;
        rx_done = 1'b0;
        step(3);
        check_cleared("reset");
        reset = 1'b0;
        step(2);

        // Directed frames from the block description.
        send_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, 1);
        wait_idle();
        send_frame(8'hFF, 8'h01, 8'h20, 0, 0, 0, 1);
        wait_idle();
        send_frame(8'h03, 8'h05, 8'h22, 0, 0, 0, 1);
        wait_idle();
        send_frame(8'h81, 8'h00, 8'h03, 0, 0, 0, 1);
        wait_idle();

        // Partial frame abandoned after 120 idle cycles.
        send_byte(8'h05, 0, at);
        check("busy_after_a", busy, 1);
        step(120);
        check("busy_after_timeout", busy, 0);
        send_frame(8'h02, 8'h02, 8'h20, 0, 0, 0, 1);
        wait_idle();

        // 100 idle cycles is still within the limit; 101 drops the partial frame.
        send_frame(8'h10, 8'h20, 8'h20, 0, TO, 0, 1);
        wait_idle();
        send_frame(8'h11, 8'h22, 8'h20, 0, 0, TO, 1);
        wait_idle();
        send_byte(8'h07, 0, at);
        send_frame(8'h02, 8'h03, 8'h20, TO + 1, 0, 0, 1);
        wait_idle();

        // rx_done during LOAD..TX_LO and TX_HI is ignored.
        base = tx_seen;
        send_frame(8'h11, 8'h22, 8'h20, 0, 0, 0, 1);
        for (int i = 0; i < int'(AW) + 3; i++) send_byte(8'($urandom), 0, at);
        wait_tx(base + 2);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, at);
        wait_idle();
        check("ignored_rx_tx_count", tx_seen, base + 2);
        send_frame(8'h40, 8'h02, 8'h02, 0, 0, 0, 1);
        wait_idle();

        // Reset during WAIT_ALU: no bytes for that frame.
        send_frame(8'h33, 8'h44, 8'h20, 0, 0, 0, 0);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_cleared("midreset");
        step(30);
        wait_idle();
        send_frame(8'h0A, 8'h0B, 8'h26, 0, 0, 0, 1);
        wait_idle();

        // Random frames, including opcode upper bits and an unlisted opcode.
        for (int i = 0; i < 24; i++) begin
            opb = {2'($urandom_range(0, 3)), pick_op($urandom_range(0, 8))};
            send_frame(8'($urandom), 8'($urandom), opb,
                       $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 1);
            wait_idle();
        end

        step(20);
        check("frame_q_empty", frame_q.size(), 0);
        check("byte_q_empty", byte_q.size(), 0);
        check("lat_q_empty", lat_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
